// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient on lo_out, remainder on hi_out.
// One quotient bit per cycle on magnitudes, then a final sign-fixup cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    div_start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic signed [WIDTH-1:0] hi_out,
  output logic signed [WIDTH-1:0] lo_out,
  output logic                    div_busy,
  output logic                    div_done,
  output logic                    div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN,
    S_ZERO
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_trial;

  // Magnitude of a two's-complement value; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] u;
    u = x;
    return x[WIDTH-1] ? ((~u) + WIDTH'(1)) : u;
  endfunction

  function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                         input logic [WIDTH-1:0] mag);
    return neg ? $signed((~mag) + WIDTH'(1)) : $signed(mag);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (div_start) w_next = (divisor == '0) ? S_ZERO : S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_SIGN;
      S_SIGN: w_next = S_IDLE;
      S_ZERO: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Restoring step: the shifted partial remainder can need WIDTH+1 bits.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_div});
    w_trial = w_shift[WIDTH-1:0] - r_div;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_done <= 1'b0;
      div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (div_start && (divisor != '0)) begin
            r_cnt    <= CNT_LAST;
            div_busy <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_SIGN: begin
          lo_out   <= apply_sign(r_sign_q, r_quo);
          hi_out   <= apply_sign(r_sign_r, r_rem);
          div_busy <= 1'b0;
          div_done <= 1'b1;
        end
        S_ZERO: begin
          div_done <= 1'b1;
          div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Working registers carry no reset; they are fully loaded before every divide.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && div_start) begin
      r_rem    <= '0;
      r_quo    <= abs_val(dividend);
      r_div    <= abs_val(divisor);
      r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_sign_r <= dividend[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_rem <= w_ge ? w_trial : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
    end
  end

endmodule
